// File: rtl/mux_gate_pkg.sv
// Shared types and the behavioural gate reference for the mux-built gate unit and its BIST.
package mux_gate_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOTA = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_BUFA = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } bist_state_e;

  function automatic logic gate_ref(op_e op, logic a, logic b);
    logic r;
    r = a;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NOR:  r = ~(a | b);
      OP_NAND: r = ~(a & b);
      OP_NOTA: r = ~a;
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      OP_BUFA: r = a;
      default: r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mux_gate_bist_cell.sv
// One-bit gate cell: every opcode realised purely from 2:1 muxes selected by A and the opcode.
module mux2 (
  input  logic sel,
  input  logic d0,
  input  logic d1,
  output logic y
);
  assign y = sel ? d1 : d0;
endmodule

module mux2_gate_cell
  import mux_gate_pkg::*;
(
  input  logic            sel_a,
  input  logic            b,
  input  logic [OP_W-1:0] op,
  output logic            y
);
  logic       bN;
  logic [7:0] lo;
  logic [7:0] hi;
  logic [3:0] loL1, hiL1;
  logic [1:0] loL2, hiL2;
  logic       loSel, hiSel;

  mux2 uInv (.sel(b), .d0(1'b1), .d1(1'b0), .y(bN));

  // Indexed by opcode: lo is the output when A=0, hi when A=1.
  assign lo = {1'b0, bN, b, 1'b1, 1'b1, bN, b, 1'b0};
  assign hi = {1'b1, b, bN, 1'b0, bN, 1'b0, 1'b1, b};

  for (genvar i = 0; i < 4; i++) begin : gL1
    mux2 uLo (.sel(op[0]), .d0(lo[2*i]), .d1(lo[2*i+1]), .y(loL1[i]));
    mux2 uHi (.sel(op[0]), .d0(hi[2*i]), .d1(hi[2*i+1]), .y(hiL1[i]));
  end

  for (genvar i = 0; i < 2; i++) begin : gL2
    mux2 uLo (.sel(op[1]), .d0(loL1[2*i]), .d1(loL1[2*i+1]), .y(loL2[i]));
    mux2 uHi (.sel(op[1]), .d0(hiL1[2*i]), .d1(hiL1[2*i+1]), .y(hiL2[i]));
  end

  mux2 uLoTop (.sel(op[2]), .d0(loL2[0]), .d1(loL2[1]), .y(loSel));
  mux2 uHiTop (.sel(op[2]), .d0(hiL2[0]), .d1(hiL2[1]), .y(hiSel));
  mux2 uOut   (.sel(sel_a), .d0(loSel),   .d1(hiSel),   .y(y));

endmodule

// File: rtl/mux_gate_bist.sv
// Registered mux-built gate unit with exhaustive self-test sweep.
// Optional MUX_GATE_BIST_FAULT_INJ_EN adds a fault_inj port that flips result bit 0.
module mux_gate_bist
  import mux_gate_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef MUX_GATE_BIST_FAULT_INJ_EN
  input  logic                 fault_inj,
`endif
  input  logic [OP_W-1:0]      op_sel,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [WIDTH-1:0]     Y,
  input  logic                 start,
  input  logic [7:0]           op_mask,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [7:0]           err_count,
  output logic [OP_W-1:0]      fail_op,
  output logic [2*WIDTH-1:0]   fail_vec
);
  // state | meaning
  // IDLE  | functional mode, waiting for start
  // RUN   | one (opIdx, vec) stimulus per cycle
  // DRAIN | checker compares the last vector
  // DONE  | one-cycle done pulse, functional mode

  localparam int VEC_W = 2 * WIDTH;

  bist_state_e        state, stateNext;
  logic [OP_W-1:0]    opIdx, firstOp, nextOp, gateOp, stimOp;
  logic               hasNext, chkValid;
  logic [VEC_W-1:0]   vec, stimVec;
  logic [7:0]         maskLat;
  logic [WIDTH-1:0]   gateA, gateB, gateY, yNext, refY, refNext;

  always_comb begin
    firstOp = '0;
    nextOp  = '0;
    hasNext = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      if (op_mask[k]) firstOp = OP_W'(k);
      if (maskLat[k] && (OP_W'(k) > opIdx)) begin
        nextOp  = OP_W'(k);
        hasNext = 1'b1;
      end
    end
  end

  assign gateOp = (state == ST_RUN) ? opIdx : op_sel;
  assign gateA  = (state == ST_RUN) ? vec[VEC_W-1:WIDTH] : A;
  assign gateB  = (state == ST_RUN) ? vec[WIDTH-1:0] : B;

  for (genvar i = 0; i < WIDTH; i++) begin : gCell
    mux2_gate_cell uCell (.sel_a(gateA[i]), .b(gateB[i]), .op(gateOp), .y(gateY[i]));
  end

`ifdef MUX_GATE_BIST_FAULT_INJ_EN
  assign yNext = gateY ^ WIDTH'(fault_inj);
`else
  assign yNext = gateY;
`endif

  always_comb begin
    refNext = '0;
    for (int i = 0; i < WIDTH; i++)
      refNext[i] = gate_ref(op_e'(opIdx), vec[WIDTH+i], vec[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE:  if (start) stateNext = (op_mask == 8'h00) ? ST_DONE : ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if ((vec == '1) && !hasNext) stateNext = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy      = 1'b1;
        stateNext = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        stateNext = ST_IDLE;
      end
      default:  stateNext = ST_IDLE;
    endcase
  end

  assign pass = (err_count == 8'h00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y         <= '0;
      refY      <= '0;
      chkValid  <= 1'b0;
      stimOp    <= '0;
      stimVec   <= '0;
      opIdx     <= '0;
      vec       <= '0;
      maskLat   <= '0;
      err_count <= '0;
      fail_op   <= '0;
      fail_vec  <= '0;
    end else begin
      Y        <= yNext;
      refY     <= refNext;
      chkValid <= (state == ST_RUN);
      stimOp   <= opIdx;
      stimVec  <= vec;
      // Y and refY both lag the stimulus by one cycle, so compare against the delayed stimulus.
      if (chkValid && (Y != refY)) begin
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        if (err_count == 8'h00) begin
          fail_op  <= stimOp;
          fail_vec <= stimVec;
        end
      end
      if ((state == ST_IDLE) && start && (op_mask != 8'h00)) begin
        maskLat   <= op_mask;
        opIdx     <= firstOp;
        vec       <= '0;
        err_count <= '0;
        fail_op   <= '0;
        fail_vec  <= '0;
      end else if (state == ST_RUN) begin
        if (vec == '1) begin
          vec <= '0;
          if (hasNext) opIdx <= nextOp;
        end else begin
          vec <= vec + VEC_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mux_gate_bist.sv
// Self-checking bench for mux_gate_bist at WIDTH=2: functional vectors, sweeps, reset and fault cases.
module tb_mux_gate_bist;
  localparam int W = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [2:0]     op_sel = '0;
  logic [W-1:0]   A = '0, B = '0, Y;
  logic           start = 1'b0;
  logic [7:0]     op_mask = '0;
  logic           busy, done, pass;
  logic [7:0]     err_count;
  logic [2:0]     fail_op;
  logic [2*W-1:0] fail_vec;
`ifdef MUX_GATE_BIST_FAULT_INJ_EN
  logic           fault_inj = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mux_gate_bist #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef MUX_GATE_BIST_FAULT_INJ_EN
    .fault_inj(fault_inj),
`endif
    .op_sel(op_sel), .A(A), .B(B), .Y(Y),
    .start(start), .op_mask(op_mask), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_op(fail_op), .fail_vec(fail_vec)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] modelGate(int op, logic [W-1:0] a, logic [W-1:0] b);
    case (op)
      0: return a & b;
      1: return a | b;
      2: return ~(a | b);
      3: return ~(a & b);
      4: return ~a;
      5: return a ^ b;
      6: return ~(a ^ b);
      default: return a;
    endcase
  endfunction

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
  } vec_t;

  task automatic applyFunc(string name, logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b,
                           logic [W-1:0] expY);
    @(posedge clk); #1;
    op_sel = op; A = a; B = b;
    @(posedge clk); #1;
    check(name, 32'(Y), 32'(expY));
  endtask

  // Runs one BIST sweep; optionally disturbs op_mask and start mid-run to show they are ignored.
  task automatic runSweep(string name, logic [7:0] mask, int changeAt, logic faultOn,
                          int expErr, logic [2:0] expFailOp, logic [2*W-1:0] expFailVec);
    logic [W-1:0] q[$];
    logic [3:0]   vv;
    logic [W-1:0] fmask;
    int m, n, busyCnt, doneAt;
    fmask = W'(faultOn);
    for (int k = 0; k < 8; k++)
      if (mask[k])
        for (int v = 0; v < 16; v++) begin
          vv = 4'(v);
          q.push_back(modelGate(k, vv[3:2], vv[1:0]) ^ fmask);
        end
    m = q.size();
    @(posedge clk); #1;
    op_mask = mask; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1; busyCnt = 0; doneAt = -1;
    while (n < 400) begin
      if (n == changeAt) begin op_mask = 8'h00; start = 1'b1; end
      if (n == changeAt + 1) start = 1'b0;
      if (busy) busyCnt++;
      if (n >= 2 && n <= m + 1)
        if (Y !== q[n-2]) check({name, " sweepY"}, 32'(Y), 32'(q[n-2]));
      if (done) begin doneAt = n; break; end
      @(posedge clk); #1;
      n++;
    end
    op_mask = 8'h00;
    check({name, " doneCycle"}, 32'(doneAt), 32'((m == 0) ? 1 : m + 2));
    check({name, " busyCycles"}, 32'(busyCnt), 32'((m == 0) ? 0 : m + 1));
    check({name, " errCount"}, 32'(err_count), 32'(expErr));
    check({name, " pass"}, 32'(pass), 32'(expErr == 0));
    check({name, " failOp"}, 32'(fail_op), 32'(expFailOp));
    check({name, " failVec"}, 32'(fail_vec), 32'(expFailVec));
    @(posedge clk); #1;
    check({name, " donePulse"}, 32'(done), 32'(0));
    check({name, " busyAfter"}, 32'(busy), 32'(0));
  endtask

  initial begin
    vec_t tbl[8];
    int n;
    logic [2:0]   rop;
    logic [W-1:0] ra, rb;

    tbl[0] = '{3'd5, 2'b10, 2'b11, 2'b01};
    tbl[1] = '{3'd4, 2'b10, 2'b00, 2'b01};
    tbl[2] = '{3'd0, 2'b11, 2'b01, 2'b01};
    tbl[3] = '{3'd1, 2'b10, 2'b01, 2'b11};
    tbl[4] = '{3'd2, 2'b00, 2'b00, 2'b11};
    tbl[5] = '{3'd3, 2'b11, 2'b11, 2'b00};
    tbl[6] = '{3'd6, 2'b10, 2'b11, 2'b10};
    tbl[7] = '{3'd7, 2'b01, 2'b10, 2'b01};

    repeat (3) @(posedge clk);
    #1;
    check("reset Y", 32'(Y), 32'(0));
    check("reset busy", 32'(busy), 32'(0));
    check("reset done", 32'(done), 32'(0));
    check("reset pass", 32'(pass), 32'(1));
    check("reset errCount", 32'(err_count), 32'(0));
    check("reset failOp", 32'(fail_op), 32'(0));
    check("reset failVec", 32'(fail_vec), 32'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      applyFunc($sformatf("table[%0d]", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].y);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = W'($urandom);
      rb  = W'($urandom);
      applyFunc($sformatf("rand op%0d a%0h b%0h", rop, ra, rb), rop, ra, rb, modelGate(int'(rop), ra, rb));
    end

    runSweep("full", 8'hFF, -1, 1'b0, 0, 3'd0, '0);
    runSweep("sparse", 8'h24, 10, 1'b0, 0, 3'd0, '0);
    runSweep("empty", 8'h00, -1, 1'b0, 0, 3'd0, '0);
    for (int i = 0; i < 3; i++)
      runSweep($sformatf("randmask%0d", i), 8'($urandom_range(1, 255)), -1, 1'b0, 0, 3'd0, '0);

    // Reset in the middle of a full sweep.
    @(posedge clk); #1;
    op_mask = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (n < 40) begin @(posedge clk); #1; n++; end
    check("midrun busy", 32'(busy), 32'(1));
    rst_n = 1'b0;
    #1;
    check("rst busy", 32'(busy), 32'(0));
    check("rst errCount", 32'(err_count), 32'(0));
    check("rst done", 32'(done), 32'(0));
    check("rst Y", 32'(Y), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 140; i++) begin
      @(posedge clk); #1;
      if (done || busy) begin
        check("abandoned sweep quiet", 32'({busy, done}), 32'(0));
        break;
      end
    end
    runSweep("after reset", 8'hFF, -1, 1'b0, 0, 3'd0, '0);

`ifdef MUX_GATE_BIST_FAULT_INJ_EN
    fault_inj = 1'b1;
    applyFunc("fault func", 3'd0, 2'b11, 2'b11, 2'b10);
    runSweep("fault", 8'h01, -1, 1'b1, 16, 3'd0, 4'h0);
    fault_inj = 1'b0;
    runSweep("fault cleared", 8'h01, -1, 1'b0, 0, 3'd0, 4'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_gate_bist.md
# mux_gate_bist

Parametrised, registered gate unit whose eight logic operations are built solely from 2:1 multiplexers, paired with an on-chip self-test engine. A functional path computes one operation per cycle on WIDTH-bit operands. The BIST sweeps every operand combination for each enabled operation, compares against a behavioural reference, and reports a pass/fail summary. It generalises the single-bit mux-built AND/OR/NOR/NAND/NOT/XOR/XNOR gates, and their exhaustive truth-table check, into reusable hardware.

## Interface
Parameters:
- WIDTH, 4: operand width in bits; legal range 1..7.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op_sel  in  3  functional opcode.
- A  in  WIDTH  functional operand A.
- B  in  WIDTH  functional operand B.
- Y  out  WIDTH  registered result.
- start  in  1  BIST request; sampled only in IDLE.
- op_mask  in  8  bit k enables opcode k in the sweep; sampled with start.
- busy  out  1  high from the cycle after start is accepted through DRAIN.
- done  out  1  one-cycle pulse at the end of a sweep.
- pass  out  1  high when err_count==0; valid from done until the next start.
- err_count  out  8  count of mismatches; saturates at 255.
- fail_op  out  3  opcode of the first mismatch.
- fail_vec  out  2*WIDTH  vector {A,B} of the first mismatch.

## Operation
- Opcodes: 0 AND, 1 OR, 2 NOR, 3 NAND, 4 NOT A, 5 XOR, 6 XNOR, 7 BUF A.
- Each bit is a 2:1 mux with select A[i] and data inputs drawn from {0, 1, B[i], ~B[i]}.
- No behavioural operators are allowed in the gate datapath.
- Operand source:
  - IDLE or DONE: Y takes gate(op_sel, A, B).
  - RUN: Y takes gate(op_idx, vec[2W-1:W], vec[W-1:0]).
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE with start=1:
  - op_mask==0: go to DONE.
  - Otherwise: go to RUN, clear err_count, fail_op and fail_vec, load op_idx with the lowest set mask bit, and set vec=0.
- RUN, per cycle:
  - Present (op_idx, vec).
  - When vec is all-ones, wrap vec to 0 and move op_idx to the next set mask bit above it. Disabled ops take no cycles.
  - After the highest enabled op reaches vec all-ones, go to DRAIN.
- Checker:
  - Compares the registered Y against a registered reference for the stimulus applied one cycle earlier.
  - On a mismatch: increment err_count (saturating).
  - On the first mismatch only: capture fail_op and fail_vec.
- DRAIN: compares the final vector, then goes to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- start outside IDLE is ignored.
- op_mask changes during RUN are ignored; a latched copy is used.

## Timing
- Reset values:
  - Y=0, busy=0, done=0.
  - pass=1, err_count=0, fail_op=0, fail_vec=0.
  - State=IDLE, op_idx=0, vec=0.
- Functional latency: 1 cycle (A/op_sel at edge n drives Y after edge n+1).
- Sweep length: M = popcount(op_mask) × 2^(2·WIDTH).
- start accepted at edge k:
  - RUN occupies cycles k+1..k+M.
  - DRAIN occupies cycle k+M+1.
  - done is high in cycle k+M+2.
- Empty mask: done is high in cycle k+1 and busy never rises.
- Reset asserted mid-sweep:
  - All outputs go to their reset values immediately.
  - The sweep is abandoned with no done pulse.

## Configuration
- Macro: MUX_GATE_BIST_FAULT_INJ_EN.
- Defined:
  - Adds input port fault_inj (1 bit).
  - While fault_inj=1, bit 0 of the gate-cell output is inverted before the Y register, in both functional and BIST modes.
- Undefined: the port is absent and the datapath is unmodified.

## Structure
- Package mux_gate_pkg holds:
  - the op_e enum (3-bit) with the eight opcodes;
  - the OP_W constant;
  - function gate_ref(op, a, b), the behavioural reference used by the checker.
- Sub-module mux2_gate_cell:
  - one bit;
  - ports sel_a, b, op, y;
  - built from mux2 instances only;
  - instantiated WIDTH times via generate.
- The FSM, counters and checker live in the top module.

## Test plan
All scenarios use WIDTH=2 (16 vectors per op).
- Functional: op_sel=5 (XOR), A=2'b10, B=2'b11 → Y=2'b01 one cycle later; op_sel=4 (NOT A), A=2'b10 → Y=2'b01.
- Full sweep: op_mask=8'hFF, start pulse → busy for 129 cycles, done in cycle k+130, pass=1, err_count=0.
- Sparse mask: op_mask=8'h24 (ops 2 and 5) → done in cycle k+34, pass=1; mid-sweep op_mask change to 8'h00 → no effect.
- Empty mask: op_mask=0 → done in cycle k+1, busy stays 0, pass=1.
- Fault injection (macro defined): fault_inj=1, op_mask=8'h01 → err_count=16, pass=0, fail_op=0, fail_vec=4'h0.
- Reset mid-sweep: rst_n low at RUN cycle 40 of an 8'hFF sweep → busy=0, err_count=0, no done; a new start then completes normally.
